// File: rtl/csa_pipe_pkg.sv
// rtl/csa_pipe_pkg.sv - shared constants and op encoding for the carry-select adder pipeline
package csa_pipe_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEG_W = 8;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int calc_nseg(int width, int seg_w);
        return width / seg_w;
    endfunction

endpackage

// File: rtl/csa_pipe_if.sv
// rtl/csa_pipe_if.sv - operand/result handshake bundle for csa_pipe
interface csa_pipe_if #(
    parameter int WIDTH = csa_pipe_pkg::DEF_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             in_cin;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_ne;
    logic             out_lt;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_ne, out_lt
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_ne, out_lt
    );

endinterface

// File: rtl/csa_seg.sv
// rtl/csa_seg.sv - combinational carry-select slice for one operand segment
module csa_seg
    import csa_pipe_pkg::*;
#(
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    localparam int H = SEG_W / 2;

    logic [H:0] lo;
    logic [H:0] hi0;
    logic [H:0] hi1;

    // The upper half is precomputed for both carry values so only a mux waits on the low half.
    assign lo  = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]} + {{H{1'b0}}, cin};
    assign hi0 = {1'b0, a[SEG_W-1:H]} + {1'b0, b[SEG_W-1:H]};
    assign hi1 = {1'b0, a[SEG_W-1:H]} + {1'b0, b[SEG_W-1:H]} + {{H{1'b0}}, 1'b1};

    assign sum  = {(lo[H] ? hi1[H-1:0] : hi0[H-1:0]), lo[H-1:0]};
    assign cout = lo[H] ? hi1[H] : hi0[H];

    // Carry into the top bit recovered from the sum bit; feeds signed-overflow detection.
    assign c_msb_in = a[SEG_W-1] ^ b[SEG_W-1] ^ sum[SEG_W-1];

endmodule

// File: rtl/csa_pipe.sv
// rtl/csa_pipe.sv - pipelined carry-select adder/subtractor with compare flags
module csa_pipe
    import csa_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG_W = DEF_SEG_W
) (
    input logic       clock,
    input logic       reset,
    csa_pipe_if.slave bus
);

    localparam int NSEG = calc_nseg(WIDTH, SEG_W);

    logic adv;

    // Per-stage inputs: stage 0 works straight off the bus, so the capture register
    // already holds segment 0 resolved and the latency stays at NSEG.
    logic [WIDTH-1:0] s_a [NSEG];
    logic [WIDTH-1:0] s_b [NSEG];
    logic             s_c [NSEG];
    logic             s_v [NSEG];

    logic [SEG_W-1:0] seg_sum  [NSEG];
    logic             seg_cout [NSEG];
    logic             seg_cmsb [NSEG];
    logic [WIDTH-1:0] n_x      [NSEG];

    logic [WIDTH-1:0] x_q [NSEG];
    logic [WIDTH-1:0] y_q [NSEG];
    logic             c_q [NSEG];
    logic             v_q [NSEG];
    logic             m_q;

    assign adv          = ~v_q[NSEG-1] | bus.out_ready;
    assign bus.in_ready = adv;

    always_comb begin
        s_a[0] = bus.in_a;
        s_b[0] = (bus.in_sub == OP_SUB) ? ~bus.in_b : bus.in_b;
        s_c[0] = (bus.in_sub == OP_SUB) ? 1'b1 : bus.in_cin;
        s_v[0] = bus.in_valid;
        for (int k = 1; k < NSEG; k++) begin
            s_a[k] = x_q[k-1];
            s_b[k] = y_q[k-1];
            s_c[k] = c_q[k-1];
            s_v[k] = v_q[k-1];
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        csa_seg #(
            .SEG_W(SEG_W)
        ) u_seg (
            .a       (s_a[k][k*SEG_W +: SEG_W]),
            .b       (s_b[k][k*SEG_W +: SEG_W]),
            .cin     (s_c[k]),
            .sum     (seg_sum[k]),
            .cout    (seg_cout[k]),
            .c_msb_in(seg_cmsb[k])
        );
    end

    // Splice the freshly resolved segment into the word; lower segments are already sums,
    // upper segments are still operand A.
    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            n_x[k]                      = s_a[k];
            n_x[k][k*SEG_W +: SEG_W]    = seg_sum[k];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NSEG; k++) begin
                v_q[k] <= 1'b0;
                x_q[k] <= '0;
                y_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            m_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < NSEG; k++) begin
                v_q[k] <= s_v[k];
                x_q[k] <= n_x[k];
                y_q[k] <= s_b[k];
                c_q[k] <= seg_cout[k];
            end
            m_q <= seg_cmsb[NSEG-1];
        end
    end

    assign bus.out_valid = v_q[NSEG-1];
    assign bus.out_sum   = x_q[NSEG-1];
    assign bus.out_cout  = c_q[NSEG-1];
    assign bus.out_ovf   = m_q ^ c_q[NSEG-1];
    assign bus.out_ne    = |x_q[NSEG-1];
    assign bus.out_lt    = x_q[NSEG-1][WIDTH-1] ^ (m_q ^ c_q[NSEG-1]);

endmodule

// File: tb/tb_csa_pipe.sv
// tb/tb_csa_pipe.sv - scoreboard bench for csa_pipe at 32/8, 16/4 and 8/8
module tb_csa_pipe;
    import csa_pipe_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    csa_pipe_if #(.WIDTH(32)) if32 ();
    csa_pipe_if #(.WIDTH(16)) if16 ();
    csa_pipe_if #(.WIDTH(8))  if8  ();

    csa_pipe #(.WIDTH(32), .SEG_W(8)) u_dut32 (.clock(clock), .reset(reset), .bus(if32.slave));
    csa_pipe #(.WIDTH(16), .SEG_W(4)) u_dut16 (.clock(clock), .reset(reset), .bus(if16.slave));
    csa_pipe #(.WIDTH(8),  .SEG_W(8)) u_dut8  (.clock(clock), .reset(reset), .bus(if8.slave));

    int          sel;
    logic        c_in_valid, c_in_sub, c_in_cin, c_out_ready;
    logic [31:0] c_a, c_b;
    logic        o_valid, o_ready;
    logic [35:0] o_res;

    assign if32.in_valid  = (sel == 0) && c_in_valid;
    assign if16.in_valid  = (sel == 1) && c_in_valid;
    assign if8.in_valid   = (sel == 2) && c_in_valid;
    assign if32.out_ready = (sel == 0) ? c_out_ready : 1'b1;
    assign if16.out_ready = (sel == 1) ? c_out_ready : 1'b1;
    assign if8.out_ready  = (sel == 2) ? c_out_ready : 1'b1;
    assign if32.in_a = c_a;        assign if32.in_b = c_b;
    assign if16.in_a = c_a[15:0];  assign if16.in_b = c_b[15:0];
    assign if8.in_a  = c_a[7:0];   assign if8.in_b  = c_b[7:0];
    assign if32.in_sub = c_in_sub; assign if32.in_cin = c_in_cin;
    assign if16.in_sub = c_in_sub; assign if16.in_cin = c_in_cin;
    assign if8.in_sub  = c_in_sub; assign if8.in_cin  = c_in_cin;

    always_comb begin
        o_valid = if32.out_valid;
        o_ready = if32.in_ready;
        o_res   = {if32.out_sum, if32.out_cout, if32.out_ovf, if32.out_ne, if32.out_lt};
        if (sel == 1) begin
            o_valid = if16.out_valid;
            o_ready = if16.in_ready;
            o_res   = {16'd0, if16.out_sum, if16.out_cout, if16.out_ovf, if16.out_ne, if16.out_lt};
        end else if (sel == 2) begin
            o_valid = if8.out_valid;
            o_ready = if8.in_ready;
            o_res   = {24'd0, if8.out_sum, if8.out_cout, if8.out_ovf, if8.out_ne, if8.out_lt};
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] op_a [16];
    logic [31:0] op_b [16];
    logic        op_sub [16];
    logic        op_cin [16];
    logic [35:0] texp [16];

    // Reference: {sum, cout, ovf, ne, lt} for a w-bit operation.
    function automatic logic [35:0] model(int w, logic [31:0] a, logic [31:0] b, logic sub, logic cin);
        logic [32:0] m, s;
        logic [31:0] bb, r;
        logic        c0, co, ov;
        m  = (33'd1 << w) - 33'd1;
        bb = sub ? ~b : b;
        c0 = sub ? 1'b1 : cin;
        s  = ({1'b0, a} & m) + ({1'b0, bb} & m) + {32'd0, c0};
        r  = s[31:0] & m[31:0];
        co = s[w];
        ov = (a[w-1] == bb[w-1]) && (r[w-1] != a[w-1]);
        return {r, co, ov, (r != 32'd0), r[w-1] ^ ov};
    endfunction

    task automatic fill_random(input int n, input int w);
        for (int i = 0; i < n; i++) begin
            op_a[i]   = $urandom;
            op_b[i]   = ($urandom_range(0, 4) == 0) ? op_a[i] : $urandom;
            op_sub[i] = 1'($urandom_range(0, 1));
            op_cin[i] = 1'($urandom_range(0, 1));
            texp[i]   = model(w, op_a[i], op_b[i], op_sub[i], op_cin[i]);
        end
    endtask

    task automatic run_ops(input string name, input int n, input int nseg, input bit stall, input bit gaps);
        logic [35:0] exp_q [$];
        int          acc_q [$];
        int          idx = 0, got = 0, cyc = 0, t;
        logic        prev_stall = 1'b0;
        logic [35:0] prev_res = '0;
        logic [35:0] e;
        logic        seen;
        while (got < n && cyc < 300) begin
            @(posedge clock); #1;
            c_in_valid = (idx < n) && !(gaps && (cyc % 3 == 1));
            if (idx < n) begin
                c_a = op_a[idx]; c_b = op_b[idx]; c_in_sub = op_sub[idx]; c_in_cin = op_cin[idx];
            end
            c_out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            @(negedge clock);
            n_tests++;
            if (o_ready !== !(o_valid && !c_out_ready)) begin
                n_fail++;
                $display("FAIL %s in_ready cyc=%0d got=%b want=%b", name, cyc, o_ready, !(o_valid && !c_out_ready));
            end
            if (prev_stall) begin
                n_tests++;
                if (o_valid !== 1'b1 || o_res !== prev_res) begin
                    n_fail++;
                    $display("FAIL %s hold cyc=%0d valid=%b res=%h want=%h", name, cyc, o_valid, o_res, prev_res);
                end
            end
            if (o_valid && c_out_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s spurious result cyc=%0d res=%h want=none", name, cyc, o_res);
                end else begin
                    e = exp_q.pop_front();
                    t = acc_q.pop_front();
                    if (o_res !== e) begin
                        n_fail++;
                        $display("FAIL %s result #%0d got=%h want=%h", name, got, o_res, e);
                    end
                    if (!stall) begin
                        n_tests++;
                        if (cyc - t !== nseg) begin
                            n_fail++;
                            $display("FAIL %s latency #%0d got=%0d want=%0d", name, got, cyc - t, nseg);
                        end
                    end
                    got++;
                end
            end
            if (c_in_valid && o_ready) begin
                exp_q.push_back(texp[idx]);
                acc_q.push_back(cyc);
                idx++;
            end
            prev_stall = o_valid && !c_out_ready;
            prev_res   = o_res;
            cyc++;
        end
        @(posedge clock); #1;
        c_in_valid  = 1'b0;
        c_out_ready = 1'b1;
        n_tests++;
        if (got != n) begin
            n_fail++;
            $display("FAIL %s timeout got=%0d results want=%0d", name, got, n);
        end
        seen = 1'b0;
        repeat (nseg + 3) begin
            @(negedge clock);
            seen = seen | o_valid;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL %s duplicate output after drain got=%b want=0", name, seen);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; sel = 0;
        c_in_valid = 1'b0; c_out_ready = 1'b1; c_in_sub = 1'b0; c_in_cin = 1'b0; c_a = '0; c_b = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        n_tests++;
        if ({o_valid, o_ready, o_res} !== {1'b0, 1'b1, 36'd0}) begin
            n_fail++;
            $display("FAIL reset_state got=%b/%b/%h want=0/1/0", o_valid, o_ready, o_res);
        end
        n_tests++;
        if ({if16.out_valid, if8.out_valid, if16.in_ready, if8.in_ready} !== 4'b0011) begin
            n_fail++;
            $display("FAIL reset_small got=%b%b%b%b want=0011", if16.out_valid, if8.out_valid, if16.in_ready, if8.in_ready);
        end
    endtask

    task automatic test_directed();
        sel = 0;
        op_a[0] = 32'hFFFF_FFFF; op_b[0] = 32'h0000_0001; op_sub[0] = 1'b0; op_cin[0] = 1'b0;
        texp[0] = {32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
        op_a[1] = 32'h7FFF_FFFF; op_b[1] = 32'h0000_0001; op_sub[1] = 1'b0; op_cin[1] = 1'b0;
        texp[1] = {32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
        op_a[2] = 32'h0000_0005; op_b[2] = 32'h0000_0007; op_sub[2] = 1'b1; op_cin[2] = 1'b0;
        texp[2] = {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b1};
        op_a[3] = 32'h1234_5678; op_b[3] = 32'h1234_5678; op_sub[3] = 1'b1; op_cin[3] = 1'b0;
        texp[3] = {32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
        op_a[4] = 32'h8000_0000; op_b[4] = 32'h0000_0001; op_sub[4] = 1'b1; op_cin[4] = 1'b0;
        texp[4] = {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1};
        op_a[5] = 32'h0000_000F; op_b[5] = 32'h0000_00F0; op_sub[5] = 1'b0; op_cin[5] = 1'b1;
        texp[5] = {32'h0000_0100, 1'b0, 1'b0, 1'b1, 1'b0};
        op_a[6] = 32'h0000_0020; op_b[6] = 32'h0000_0010; op_sub[6] = 1'b1; op_cin[6] = 1'b1;
        texp[6] = {32'h0000_0010, 1'b1, 1'b0, 1'b1, 1'b0};
        run_ops("directed", 7, 4, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        sel = 0;
        fill_random(8, 32);
        run_ops("backpressure", 8, 4, 1'b1, 1'b0);
    endtask

    task automatic test_bubbles();
        sel = 0;
        fill_random(8, 32);
        run_ops("bubbles_free", 8, 4, 1'b0, 1'b1);
        fill_random(8, 32);
        run_ops("bubbles_stall", 8, 4, 1'b1, 1'b1);
    endtask

    task automatic test_reset_midflight();
        logic seen;
        int   wait_cyc;
        sel = 0;
        c_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            c_in_valid = 1'b1; c_a = 32'(i + 1); c_b = 32'h10; c_in_sub = 1'b0; c_in_cin = 1'b0;
        end
        @(posedge clock); #1;
        c_in_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_tests++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_reset_valid got=%b want=0", o_valid);
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clock);
            seen = seen | o_valid;
        end
        n_tests++;
        if ({seen, o_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL midflight_no_result got valid_seen=%b in_ready=%b want 0/1", seen, o_ready);
        end
        // Async check: reset lands mid-cycle while a result is being held.
        @(posedge clock); #1;
        c_in_valid = 1'b1; c_out_ready = 1'b0; c_a = 32'h55; c_b = 32'h22;
        @(posedge clock); #1;
        c_in_valid = 1'b0;
        wait_cyc = 0;
        @(negedge clock);
        while (!o_valid && wait_cyc < 10) begin
            @(negedge clock);
            wait_cyc++;
        end
        n_tests++;
        if (o_res !== {32'h0000_0077, 4'b0010}) begin
            n_fail++;
            $display("FAIL async_setup got valid=%b res=%h want 1/%h", o_valid, o_res, {32'h0000_0077, 4'b0010});
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({o_valid, o_res} !== 37'd0) begin
            n_fail++;
            $display("FAIL async_reset got valid=%b res=%h want 0/0", o_valid, o_res);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        c_out_ready = 1'b1;
    endtask

    task automatic test_sweep();
        sel = 1;
        fill_random(10, 16);
        run_ops("w16_free", 10, 4, 1'b0, 1'b0);
        fill_random(10, 16);
        run_ops("w16_stall", 10, 4, 1'b1, 1'b1);
        sel = 2;
        fill_random(10, 8);
        run_ops("w8_free", 10, 1, 1'b0, 1'b0);
        fill_random(10, 8);
        run_ops("w8_stall", 10, 1, 1'b1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_bubbles();
        test_reset_midflight();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
